// File: rtl/spi_master_core.sv
// SPI master shift engine: drives sclk/mosi/cs_n from divider ticks, returns the received word.
// Latency: done fires 2*DATA_W+2 ticks after start is accepted (plus up to one tick of phase alignment).
// No backpressure: start is taken only while idle; starts seen while busy or finishing are dropped.
module spi_master_core #(
   parameter int unsigned DATA_W = 8,
   parameter bit          CPOL   = 1'b0,
   parameter bit          CPHA   = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tick_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic              cs_n_o
);

   // Edge counter spans 0 .. 2*DATA_W-1 (one count per sclk edge).
   localparam int unsigned      CNT_W     = $clog2(2 * DATA_W);
   localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_XFER   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_data_q,  rx_data_d;
   logic              sclk_q,     sclk_d;
   logic              mosi_q,     mosi_d;
   logic              cs_n_q,     cs_n_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;

   // Edge classification inside XFER: even counts are leading edges.
   logic xfer_tick;
   logic lead_edge;
   logic last_edge;
   logic shift_evt;
   logic sample_evt;

   // Decode which data action the current tick performs for the selected SPI mode.
   always_comb begin
      xfer_tick  = (state_q == ST_XFER) && tick_i;
      lead_edge  = ~edge_cnt_q[0];
      last_edge  = (edge_cnt_q == LAST_EDGE);
      // CPHA=0 shifts on trailing edges (the MSB was already placed at accept, so the
      // final trailing edge has nothing left to drive); CPHA=1 shifts on every leading edge.
      shift_evt  = xfer_tick && (CPHA ? lead_edge : (~lead_edge && ~last_edge));
      sample_evt = xfer_tick && (CPHA ? ~lead_edge : lead_edge);
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: ticks drive progress everywhere except IDLE and FINISH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_SETUP;
         ST_SETUP:  if (tick_i) state_d = ST_XFER;
         ST_XFER:   if (tick_i && last_edge) state_d = ST_HOLD;
         ST_HOLD:   if (tick_i) state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next-values per state; every SPI pin is registered so it cannot glitch.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A tick coinciding with start is deliberately not used here.
            if (start_i) begin
               cs_n_d = 1'b0;
               busy_d = 1'b1;
               if (CPHA) begin
                  tx_shift_d = tx_data_i;
               end else begin
                  // CPHA=0 needs the MSB on the wire before the first (sampling) edge.
                  mosi_d     = tx_data_i[DATA_W-1];
                  tx_shift_d = {tx_data_i[DATA_W-2:0], 1'b0};
               end
            end
         end
         ST_SETUP: begin
            if (tick_i) begin
               edge_cnt_d = '0;
            end
         end
         ST_XFER: begin
            if (tick_i) begin
               sclk_d     = ~sclk_q;
               edge_cnt_d = last_edge ? '0 : edge_cnt_q + CNT_W'(1);
            end
            if (shift_evt) begin
               mosi_d     = tx_shift_q[DATA_W-1];
               tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end
            if (sample_evt) begin
               rx_shift_d = {rx_shift_q[DATA_W-2:0], miso_i};
            end
         end
         ST_HOLD: begin
            // cs_n releases on the same edge that publishes the word and raises done.
            if (tick_i) begin
               cs_n_d    = 1'b1;
               done_d    = 1'b1;
               rx_data_d = rx_shift_q;
            end
         end
         ST_FINISH: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
            cs_n_d = 1'b1;
            sclk_d = CPOL;
         end
      endcase
   end

   // Datapath and pin registers; reset also aborts any transfer in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_cnt_q <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         sclk_q     <= CPOL;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;
   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
   assign cs_n_o    = cs_n_q;

endmodule
